// File: rtl/bist_signature_check.sv
// rtl/bist_signature_check.sv - MISR response compaction and pass/fail verdict behind the BIST controller
module bist_signature_check #(
    parameter int           W         = 8,
    parameter logic [W-1:0] POLY      = 8'h1D,
    parameter logic [W-1:0] SEED      = '0,
    parameter logic [W-1:0] GOLDEN    = 8'h00,
    parameter int           EXP_COUNT = 0
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         RUNNING,
    input  logic         OUT,
    input  logic         FINISH,
    input  logic         BIST_END,
    input  logic [W-1:0] RESP,
    output logic [W-1:0] SIGNATURE,
    output logic [7:0]   VEC_COUNT,
    output logic         DONE,
    output logic         PASS,
    output logic         FAIL
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPACT,
        S_COMPARE,
        S_DONE
    } state_t;

    localparam logic [7:0] EXP_CNT8 = 8'(EXP_COUNT);

    state_t       state_q;
    logic [W-1:0] sig_q;
    logic [W-1:0] sig_d;
    logic [7:0]   cnt_q;
    logic [7:0]   cnt_d;
    logic         match_d;
    logic         match_q;
    logic         done_q;
    logic         pass_q;
    logic         fail_q;

    // OUT alone qualifies a capture; the counting-phase flag carries no extra information here.
    logic unused_running;
    assign unused_running = RUNNING;

    always_comb begin
        sig_d   = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ RESP;
        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        match_d = (sig_q == GOLDEN) && ((EXP_COUNT == 0) || (cnt_q == EXP_CNT8));
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            sig_q   <= SEED;
            cnt_q   <= 8'd0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_COMPACT: begin
                    if (OUT) begin
                        sig_q <= sig_d;
                        cnt_q <= cnt_d;
                    end
                    if (FINISH) begin
                        state_q <= S_COMPARE;
                    end else if (OUT) begin
                        state_q <= S_COMPACT;
                    end
                end
                S_COMPARE: begin
                    match_q <= match_d;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    // Verdict is published on the first DONE cycle; a dropped BIST_END rearms instead.
                    if (!BIST_END) begin
                        state_q <= S_IDLE;
                        sig_q   <= SEED;
                        cnt_q   <= 8'd0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        fail_q  <= 1'b0;
                    end else if (!done_q) begin
                        done_q  <= 1'b1;
                        pass_q  <= match_q;
                        fail_q  <= !match_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign SIGNATURE = sig_q;
    assign VEC_COUNT = cnt_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign FAIL      = fail_q;

endmodule

// File: tb/tb_bist_signature_check.sv
// tb/tb_bist_signature_check.sv - table-driven and randomized checks of bist_signature_check
module tb_bist_signature_check;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       RUNNING = 1'b0;
    logic       OUT = 1'b0;
    logic       FINISH = 1'b0;
    logic       BIST_END = 1'b0;
    logic [7:0] RESP = 8'h00;

    logic [7:0] sig, cnt, sig0, cnt0;
    logic       done, pass, fail, done0, pass0, fail0;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    bist_signature_check #(.W(8), .POLY(8'h1D), .SEED(8'h00), .GOLDEN(8'h1D), .EXP_COUNT(2)) dut (
        .CLK(CLK), .RESET(RESET), .RUNNING(RUNNING), .OUT(OUT), .FINISH(FINISH),
        .BIST_END(BIST_END), .RESP(RESP), .SIGNATURE(sig), .VEC_COUNT(cnt),
        .DONE(done), .PASS(pass), .FAIL(fail)
    );

    bist_signature_check #(.W(8), .POLY(8'h1D), .SEED(8'h00), .GOLDEN(8'h00), .EXP_COUNT(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .RUNNING(RUNNING), .OUT(OUT), .FINISH(FINISH),
        .BIST_END(BIST_END), .RESP(RESP), .SIGNATURE(sig0), .VEC_COUNT(cnt0),
        .DONE(done0), .PASS(pass0), .FAIL(fail0)
    );

    typedef struct {
        logic       out;
        logic       finish;
        logic       bend;
        logic [7:0] resp;
        logic [7:0] sig;
        logic [7:0] cnt;
        logic       done;
        logic       pass;
        logic       fail;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic o, logic f, logic be, logic [7:0] r,
                                logic [7:0] s, logic [7:0] c, logic d, logic p, logic fl);
        vec_t v;
        v.out = o; v.finish = f; v.bend = be; v.resp = r;
        v.sig = s; v.cnt = c; v.done = d; v.pass = p; v.fail = fl;
        return v;
    endfunction

    function automatic int misr(int s, int r);
        return ((s * 2) % 256) ^ ((s >= 128) ? 'h1D : 0) ^ r;
    endfunction

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_outs(string tag, int s, int c, int d, int p, int f);
        chk({tag, ".sig"}, sig, s);
        chk({tag, ".cnt"}, cnt, c);
        chk({tag, ".done"}, done, d);
        chk({tag, ".pass"}, pass, p);
        chk({tag, ".fail"}, fail, f);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int msig, mcnt, len, r;
        bit both, exp_pass;

        // reset state
        #12;
        chk_outs("reset", 0, 0, 0, 0, 0);
        @(negedge CLK);
        RESET = 1'b0;
        step();
        chk_outs("idle", 0, 0, 0, 0, 0);

        // pass run, twice
        for (int k = 0; k < 2; k++) begin
            tbl.push_back(mk(1, 0, 0, 8'h80, 8'h80, 1, 0, 0, 0));
            tbl.push_back(mk(1, 0, 0, 8'h00, 8'h1D, 2, 0, 0, 0));
            tbl.push_back(mk(0, 1, 1, 8'h00, 8'h1D, 2, 0, 0, 0));
            tbl.push_back(mk(0, 0, 1, 8'h00, 8'h1D, 2, 0, 0, 0));
            tbl.push_back(mk(0, 0, 1, 8'h00, 8'h1D, 2, 1, 1, 0));
            tbl.push_back(mk(1, 1, 1, 8'h55, 8'h1D, 2, 1, 1, 0));
            tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
        end
        // signature mismatch
        tbl.push_back(mk(1, 0, 0, 8'h81, 8'h81, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 8'h1F, 2, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8'h00, 8'h1F, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h1F, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h1F, 2, 1, 0, 1));
        tbl.push_back(mk(1, 0, 1, 8'h33, 8'h1F, 2, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
        // row-boundary gap: OUT=0 holds, 5 vectors counted
        tbl.push_back(mk(1, 0, 0, 8'h01, 8'h01, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h02, 8'h00, 2, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h03, 8'h03, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'hAA, 8'h03, 3, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h04, 8'h02, 4, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h05, 8'h01, 5, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8'h00, 8'h01, 5, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h01, 5, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h01, 5, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
        // FINISH together with the last capture uses the updated signature
        tbl.push_back(mk(1, 0, 0, 8'h80, 8'h80, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 8'h00, 8'h1D, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h1D, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h1D, 2, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            OUT = tbl[i].out; FINISH = tbl[i].finish; BIST_END = tbl[i].bend;
            RESP = tbl[i].resp; RUNNING = !tbl[i].bend;
            step();
            chk_outs($sformatf("tbl[%0d]", i), tbl[i].sig, tbl[i].cnt, tbl[i].done, tbl[i].pass, tbl[i].fail);
        end

        // asynchronous reset mid-compaction, then a zero-vector run
        OUT = 1'b1; RUNNING = 1'b1; BIST_END = 1'b0;
        for (int i = 0; i < 3; i++) begin
            RESP = 8'(8'h11 * (i + 1));
            step();
        end
        chk("pre_reset.cnt", cnt, 3);
        OUT = 1'b0;
        #2 RESET = 1'b1;
        #1;
        chk_outs("async_reset", 0, 0, 0, 0, 0);
        #1 RESET = 1'b0;
        FINISH = 1'b1; BIST_END = 1'b1; RUNNING = 1'b0;
        step();
        FINISH = 1'b0;
        step();
        chk("zero_run.early_done", done, 0);
        step();
        chk_outs("zero_run", 0, 0, 1, 0, 1);
        chk("zero_run.dut0_done", done0, 1);
        chk("zero_run.dut0_pass", pass0, 1);
        chk("zero_run.dut0_fail", fail0, 0);
        BIST_END = 1'b0;
        step();
        chk_outs("zero_run.rearm", 0, 0, 0, 0, 0);

        // randomized runs against the reference model
        for (int run = 0; run < 30; run++) begin
            len  = (run % 10 == 9) ? $urandom_range(256, 290) : $urandom_range(0, 10);
            both = (len > 0) && ($urandom_range(0, 1) == 1);
            msig = 0;
            mcnt = 0;
            RUNNING = 1'b1; BIST_END = 1'b0; FINISH = 1'b0;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    OUT = 1'b0; RESP = 8'($urandom_range(0, 255));
                    step();
                    chk("rnd.gap.sig", sig, msig);
                    chk("rnd.gap.cnt", cnt, mcnt);
                end
                r = $urandom_range(0, 255);
                OUT = 1'b1; RESP = 8'(r);
                if (both && i == len - 1) begin
                    FINISH = 1'b1; BIST_END = 1'b1;
                end
                step();
                msig = misr(msig, r);
                mcnt = (mcnt < 255) ? mcnt + 1 : 255;
                chk("rnd.sig", sig, msig);
                chk("rnd.cnt", cnt, mcnt);
            end
            if (!both) begin
                OUT = 1'b0; FINISH = 1'b1; BIST_END = 1'b1;
                step();
            end
            OUT = 1'b0; FINISH = 1'b0; RUNNING = 1'b0;
            step();
            chk("rnd.latency", done, 0);
            step();
            exp_pass = (msig == 'h1D) && (mcnt == 2);
            chk_outs("rnd.verdict", msig, mcnt, 1, int'(exp_pass), int'(!exp_pass));
            chk("rnd.dut0_pass", pass0, int'(msig == 0));
            chk("rnd.dut0_fail", fail0, int'(msig != 0));
            for (int h = 0; h < 2; h++) begin
                OUT = 1'b1; RESP = 8'($urandom_range(0, 255)); FINISH = 1'($urandom_range(0, 1));
                step();
                chk_outs("rnd.hold", msig, mcnt, 1, int'(exp_pass), int'(!exp_pass));
            end
            OUT = 1'b0; FINISH = 1'b0; BIST_END = 1'b0;
            step();
            chk_outs("rnd.rearm", 0, 0, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bist_signature_check.md
Name: bist_signature_check

Overview:
- Response-compaction and verdict stage directly downstream of the BIST controller.
- Compacts the CUT response word into a MISR on every controller OUT cycle and counts captured vectors.
- On the controller FINISH pulse, compares the signature and the count against golden values.
- Holds PASS/FAIL with DONE while the controller keeps BIST_END high, then rearms for the next run.

Parameters:
- W, 8, response/MISR width (≥2).
- POLY, 8'h1D, Galois feedback polynomial (W bits, x^W term implicit).
- SEED, 0, MISR value at reset and at rearm.
- GOLDEN, 8'h00, expected final signature.
- EXP_COUNT, 0, expected captured-vector count; 0 disables the count check.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- RUNNING  in  1  controller counting phase.
- OUT  in  1  controller capture strobe; RESP is valid this cycle.
- FINISH  in  1  controller one-cycle end-of-run pulse.
- BIST_END  in  1  controller end flag; stays high until the next run starts.
- RESP  in  W  CUT response word.
- SIGNATURE  out  W  current MISR contents.
- VEC_COUNT  out  8  vectors captured this run.
- DONE  out  1  verdict valid.
- PASS  out  1  signature and count matched.
- FAIL  out  1  mismatch.

Behaviour:
- Reset is asynchronous and active-high; clock is CLK (rising edge).
- Reset values:
  - state = IDLE.
  - SIGNATURE = SEED.
  - VEC_COUNT = 0.
  - DONE = PASS = FAIL = 0.
- RESET asserted mid-run forces these values immediately, in any state.
- MISR step, applied on every cycle in which OUT=1 in IDLE or COMPACT:
  - sig_next = {sig[W-2:0],1'b0} ^ (sig[W-1] ? POLY : 0) ^ RESP.
  - VEC_COUNT increments with the same step and saturates at 255 (no wrap).
- OUT=0 with RUNNING=1 (controller row-boundary cycle): hold SIGNATURE and VEC_COUNT.
- FSM (registered outputs):
  - IDLE:
    - OUT=1 → capture, go COMPACT.
    - FINISH=1 → go COMPARE (zero-vector run).
    - Otherwise stay.
  - COMPACT:
    - OUT=1 → capture.
    - FINISH=1 → go COMPARE.
    - If FINISH and OUT are both 1, the capture still applies and the compare uses the updated signature.
  - COMPARE (exactly 1 cycle):
    - match = (SIGNATURE==GOLDEN) && (EXP_COUNT==0 || VEC_COUNT==EXP_COUNT).
    - Next cycle: PASS=match, FAIL=!match, DONE=1.
    - Go DONE.
  - DONE:
    - Hold SIGNATURE, VEC_COUNT, PASS, FAIL and DONE.
    - Ignore OUT and FINISH.
    - When BIST_END=0 (controller restarted) → IDLE.
    - On that same edge: SIGNATURE=SEED, VEC_COUNT=0, DONE=PASS=FAIL=0.
- Latency: FINISH sampled at edge k → DONE/PASS/FAIL high after edge k+2.
- PASS and FAIL are never both 1. Both are 0 whenever DONE=0.
- A capture arriving in IDLE starts compaction from SEED. There is no separate init pulse.
- Rearm happens only via DONE→IDLE, so the signature of a finished run stays stable until the next start.

Test Plan:
- W=8, POLY=8'h1D, SEED=0: OUT=1 with RESP=8'h80, then RESP=8'h00 → SIGNATURE 8'h80, then 8'h1D; VEC_COUNT=2.
- GOLDEN=8'h1D, EXP_COUNT=2: run the sequence above, pulse FINISH one cycle later → 2 edges later DONE=1, PASS=1, FAIL=0; values held while BIST_END=1.
- Same run with RESP 8'h81 on the first vector → FAIL=1, PASS=0, DONE=1.
- OUT=1 for 3 cycles, OUT=0 for 1 cycle (RUNNING=1), OUT=1 for 2 cycles, EXP_COUNT=5 → VEC_COUNT=5 (not 6); signature unchanged on the OUT=0 cycle.
- In DONE, drop BIST_END to 0 → next edge: SIGNATURE=8'h00, VEC_COUNT=0, DONE=PASS=FAIL=0. A second identical run gives the same verdict.
- Assert RESET asynchronously mid-COMPACT after 3 captures → outputs return to reset values immediately; a FINISH pulse right after deassert yields DONE=1, FAIL=1 (count 0 ≠ 2).
